cordic_phase_gen: RTL and testbench
===================================

Name: cordic_phase_gen

Overview:
- Upstream stage of the pipelined CORDIC sine/cosine core.
- A phase accumulator (NCO) advances a full-turn phase word by a frequency control word.
- It range-reduces the phase to [-pi/2, pi/2) and converts it to the signed Q2.6 angle the CORDIC "in" port accepts.
- It also emits a quadrant flip flag, delayed to align with the CORDIC outputs, so downstream logic can negate sine and cosine together.

Parameters:
- PHASE_W, 16, phase accumulator width; 2^PHASE_W = one full turn (2*pi).
- ANGLE_W, 8, output angle width, signed Q2.6.
- ANGLE_K, 402, round(2*pi*64); scales a turn fraction to Q2.6 radians.
- CORDIC_LAT, 10, CORDIC pipeline latency in cycles; length of the flip delay line.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- en  in  1  sample the current phase, then advance it by fcw.
- fcw  in  PHASE_W  frequency control word, unsigned, wraps mod 2^PHASE_W.
- load  in  1  load phase_init into the accumulator; has priority over en.
- phase_init  in  PHASE_W  phase value used by load.
- angle  out  ANGLE_W  signed Q2.6 reduced angle; drives CORDIC "in".
- angle_valid  out  1  angle holds a new sample this cycle.
- flip_out  out  1  negate both CORDIC sine and cosine; aligned with CORDIC output.
- out_valid  out  1  angle_valid delayed by CORDIC_LAT cycles.

Behaviour:
- Reset (rst=0 at a rising edge) clears: phase, all pipeline registers, the whole delay line, angle=0, angle_valid=0, flip_out=0, out_valid=0.
- Reset takes effect mid-operation as well; in-flight samples are discarded.
- Accumulator, priority order per edge:
  - rst=0 → reset.
  - else load → phase <= phase_init; no sample is taken.
  - else en → sample current (pre-update) phase into stage A; phase <= phase + fcw, modulo 2^PHASE_W with silent wrap.
  - else phase holds; stage A valid = 0.
- Stage A (range reduction), with s = sampled phase read as signed:
  - If s[PHASE_W-1] != s[PHASE_W-2] (|angle| >= pi/2): flip=1 and s' = s with MSB inverted (adds pi, mod 2^PHASE_W).
  - Otherwise flip=0 and s' = s.
  - s' always lies in [-2^(PHASE_W-2), 2^(PHASE_W-2)).
  - Exactly pi/2 (top bits 01) → flip=1, s' = -2^(PHASE_W-2).
  - Exactly -pi/2 (top bits 11) → flip=0, s' unchanged.
- Stage B (scale): angle = (s' * ANGLE_K + 2^(PHASE_W-1)) >>> PHASE_W.
  - Signed, round-half-up, product width PHASE_W+10.
  - Result range [-100, 100]; no saturation needed; truncate to ANGLE_W.
- Register updates:
  - angle and stage-B flip update only on a valid stage-A sample; otherwise they hold.
  - angle_valid pulses for one cycle per sample.
- Latency: a sample taken at edge N appears on angle/angle_valid after edge N+2.
- Delay line: {angle_valid, flip} shift through CORDIC_LAT registers every cycle, independent of en.
  - out_valid/flip_out equal angle_valid/flip exactly CORDIC_LAT cycles earlier.
  - flip_out is 0 whenever out_valid is 0.
- Back-to-back samples (en held high): one angle per cycle, no bubbles.
- load during streaming: samples already in stages A/B drain normally; the next sample uses phase_init.

Test Plan:
1. Reset: rst=0 for 2 edges with en=1, fcw=0x1234 → phase=0, angle=0, angle_valid=0, flip_out=0, out_valid=0.
2. load phase_init=0x2000 (pi/4), then en=1, fcw=0 → angle=50 (8'b00_110010), flip=0, angle_valid two edges after the en edge; out_valid and flip_out=0 CORDIC_LAT cycles after that.
3. phase_init=0x6000 (3pi/4) → angle=-50 (8'b11_001110), flip=1; phase_init=0xA000 (-3pi/4) → angle=50, flip=1.
4. Boundaries:
   - 0x4000 (pi/2) → angle=-100 (0x9C), flip=1.
   - 0xC000 (-pi/2) → angle=-100, flip=0.
   - 0x8000 (pi) → angle=0, flip=1.
   - 0x0000 → angle=0, flip=0.
5. Sweep: load 0, fcw=0x1000, en=1 for 20 cycles.
   - Angles 0,25,50,75,-100,-75,-50,-25,0,… with flip 0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0.
   - Phase wraps after 16 samples and the sequence repeats.
   - out_valid is high for exactly 20 cycles.
6. en gaps and reset:
   - en toggled 1,0,1 → angle_valid pulses mirror the pattern; angle holds during the gap.
   - Assert rst=0 mid-stream → out_valid and flip_out drop at the next edge, and stay 0 for CORDIC_LAT cycles after release until new samples arrive.

Source files
------------

// File: rtl/cordic_phase_gen_if.sv
// rtl/cordic_phase_gen_if.sv - control and sample bus between the NCO front end and its user
interface cordic_phase_gen_if #(
  parameter int PHASE_W = 16,
  parameter int ANGLE_W = 8
);
  logic               en;
  logic [PHASE_W-1:0] fcw;
  logic               load;
  logic [PHASE_W-1:0] phase_init;
  logic [ANGLE_W-1:0] angle;
  logic               angle_valid;
  logic               flip_out;
  logic               out_valid;

  modport master (
    output en, fcw, load, phase_init,
    input  angle, angle_valid, flip_out, out_valid
  );

  modport slave (
    input  en, fcw, load, phase_init,
    output angle, angle_valid, flip_out, out_valid
  );
endinterface

// File: rtl/cordic_phase_gen.sv
// rtl/cordic_phase_gen.sv - NCO phase accumulator, range reduction to [-pi/2, pi/2) and Q2.6 scaling
module cordic_phase_gen #(
  parameter int PHASE_W    = 16,
  parameter int ANGLE_W    = 8,
  parameter int ANGLE_K    = 402,
  parameter int CORDIC_LAT = 10
) (
  input  logic               clk,
  input  logic               rst,
  cordic_phase_gen_if.slave  bus
);
  localparam int PROD_W = PHASE_W + 10;
  localparam logic signed [PROD_W-1:0] K_EXT = PROD_W'(ANGLE_K);
  localparam logic signed [PROD_W-1:0] RND   = PROD_W'(1) << (PHASE_W - 1);

  logic [PHASE_W-1:0]        phase;
  logic [PHASE_W-1:0]        samp;
  logic                      samp_v;
  logic signed [PHASE_W-1:0] red;
  logic                      red_flip;
  logic                      red_v;
  logic [ANGLE_W-1:0]        angle_q;
  logic                      angle_v_q;
  logic                      b_flip;
  logic [CORDIC_LAT-1:0]     dl_v;
  logic [CORDIC_LAT-1:0]     dl_f;

  logic                      a_flip;
  logic signed [PHASE_W-1:0] red_next;
  logic signed [PROD_W-1:0]  red_ext;
  logic signed [PROD_W-1:0]  prod_sum;
  logic [ANGLE_W-1:0]        angle_next;
  logic                      unused_bits;

  // Top two bits disagree means |angle| >= pi/2; inverting the MSB adds pi.
  assign a_flip   = samp[PHASE_W-1] ^ samp[PHASE_W-2];
  assign red_next = {samp[PHASE_W-1] ^ a_flip, samp[PHASE_W-2:0]};

  assign red_ext     = {{10{red[PHASE_W-1]}}, red};
  assign prod_sum    = red_ext * K_EXT + RND;
  assign angle_next  = prod_sum[PHASE_W+ANGLE_W-1:PHASE_W];
  assign unused_bits = ^{prod_sum[PROD_W-1:PHASE_W+ANGLE_W], prod_sum[PHASE_W-1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase     <= '0;
      samp      <= '0;
      samp_v    <= 1'b0;
      red       <= '0;
      red_flip  <= 1'b0;
      red_v     <= 1'b0;
      angle_q   <= '0;
      angle_v_q <= 1'b0;
      b_flip    <= 1'b0;
      dl_v      <= '0;
      dl_f      <= '0;
    end else begin
      samp_v <= 1'b0;
      if (bus.load) begin
        phase <= bus.phase_init;
      end else if (bus.en) begin
        samp   <= phase;
        samp_v <= 1'b1;
        phase  <= phase + bus.fcw;
      end

      red_v <= samp_v;
      if (samp_v) begin
        red      <= red_next;
        red_flip <= a_flip;
      end

      angle_v_q <= red_v;
      if (red_v) begin
        angle_q <= angle_next;
        b_flip  <= red_flip;
      end

      // Flip is gated by valid so the delayed flag is never set without a sample.
      dl_v <= {dl_v[CORDIC_LAT-2:0], angle_v_q};
      dl_f <= {dl_f[CORDIC_LAT-2:0], angle_v_q & b_flip};
    end
  end

  assign bus.angle       = angle_q;
  assign bus.angle_valid = angle_v_q;
  assign bus.flip_out    = dl_f[CORDIC_LAT-1];
  assign bus.out_valid   = dl_v[CORDIC_LAT-1];
endmodule

// File: tb/tb_cordic_phase_gen.sv
// tb/tb_cordic_phase_gen.sv - scoreboard bench for cordic_phase_gen with directed vectors
module tb_cordic_phase_gen;
  localparam int LAT = 10;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   ov_cnt = 0;
  int   last_angle = 0;
  bit   mon_en = 1'b0;
  exp_t q_ang[$];
  exp_t q_out[$];

  cordic_phase_gen_if #(.PHASE_W(16), .ANGLE_W(8)) bus ();

  cordic_phase_gen #(
    .PHASE_W(16), .ANGLE_W(8), .ANGLE_K(402), .CORDIC_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.angle_valid) begin
        if (q_ang.size() == 0) begin
          check("angle_unexpected", 1, 0);
        end else begin
          e = q_ang.pop_front();
          check("angle", int'($signed(bus.angle)), e.val);
          check("angle_cycle", cyc, e.due);
          last_angle = e.val;
        end
      end else begin
        check("angle_hold", int'($signed(bus.angle)), last_angle);
      end
      if (q_ang.size() > 0 && q_ang[0].due < cyc) begin
        e = q_ang.pop_front();
        check("angle_missing", cyc, e.due);
      end

      if (bus.out_valid) begin
        ov_cnt++;
        if (q_out.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          e = q_out.pop_front();
          check("flip_out", int'(bus.flip_out), e.val);
          check("out_cycle", cyc, e.due);
        end
      end else begin
        check("flip_idle", int'(bus.flip_out), 0);
      end
      if (q_out.size() > 0 && q_out[0].due < cyc) begin
        e = q_out.pop_front();
        check("out_missing", cyc, e.due);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] p);
    bus.load = 1'b1;
    bus.en = 1'b0;
    bus.phase_init = p;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic do_sample(input logic [15:0] f, input int ea, input int ef);
    bus.en = 1'b1;
    bus.fcw = f;
    q_ang.push_back('{val: ea, due: cyc + 3});
    q_out.push_back('{val: ef, due: cyc + 3 + LAT});
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  int sweep_angle[8] = '{0, 25, 50, 75, -100, -75, -50, -25};
  int ov_snap;

  initial begin
    bus.en = 1'b1;
    bus.fcw = 16'h1234;
    bus.load = 1'b0;
    bus.phase_init = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_angle", int'($signed(bus.angle)), 0);
    check("rst_angle_valid", int'(bus.angle_valid), 0);
    check("rst_flip_out", int'(bus.flip_out), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    bus.en = 1'b0;
    rst = 1'b1;
    mon_en = 1'b1;

    // Phase came out of reset at zero.
    do_sample(16'h0000, 0, 0);

    do_load(16'h2000); do_sample(16'h0000, 50, 0);
    do_load(16'h6000); do_sample(16'h0000, -50, 1);
    do_load(16'hA000); do_sample(16'h0000, 50, 1);
    do_load(16'h4000); do_sample(16'h0000, -100, 1);
    do_load(16'hC000); do_sample(16'h0000, -100, 0);
    do_load(16'h8000); do_sample(16'h0000, 0, 1);
    do_load(16'h0000); do_sample(16'h0000, 0, 0);
    idle(LAT + 6);

    ov_snap = ov_cnt;
    do_load(16'h0000);
    for (int i = 0; i < 20; i++)
      do_sample(16'h1000, sweep_angle[i % 8], ((i % 16) >= 4 && (i % 16) < 12) ? 1 : 0);
    idle(LAT + 6);
    check("sweep_out_valid_cycles", ov_cnt - ov_snap, 20);

    do_load(16'h2000);
    do_sample(16'h2000, 50, 0);
    idle(3);
    do_sample(16'h2000, -100, 1);
    do_sample(16'h2000, -50, 1);
    for (int i = 0; i < 14; i++)
      do_sample(16'h0000, 0, 1);

    bus.en = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    q_ang.delete();
    q_out.delete();
    last_angle = 0;
    @(negedge clk);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_flip_out", int'(bus.flip_out), 0);
    check("midrst_angle_valid", int'(bus.angle_valid), 0);
    bus.en = 1'b0;
    rst = 1'b1;
    idle(LAT + 4);

    do_sample(16'h0000, 0, 0);
    idle(LAT + 6);
    check("angle_queue_drained", q_ang.size(), 0);
    check("out_queue_drained", q_out.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
